// File: rtl/fault_recorder_pkg.sv
// Shared definitions for the fault recorder: cause codes, address-select
// encodings, FSM state type and a helper macro for building CAUSE_MAP.
package fault_recorder_pkg;

  // Cause codes (legacy encoder values kept)
  localparam logic [7:0] CAUSE_NONE = 8'h00;
  localparam logic [7:0] CAUSE_CORE = 8'h01;
  localparam logic [7:0] CAUSE_IBUS = 8'h02;
  localparam logic [7:0] CAUSE_DBUS = 8'h03;
  localparam logic [7:0] CAUSE_IPER = 8'h04;
  localparam logic [7:0] CAUSE_DPER = 8'h05;

  // Address-bus select encodings
  localparam int ASEL_IBUS = 0;
  localparam int ASEL_DBUS = 1;
  localparam int ASEL_PBUS = 2;
  localparam int ASEL_PC   = 3;

  typedef enum logic [0:0] {
    FR_IDLE    = 1'b0,
    FR_FAULTED = 1'b1
  } fr_state_e;

endpackage

// Place cause CODE for source IDX into an N-source CAUSE_MAP; OR the
// results together to build the full map.
`define FR_CAUSE_AT(N, IDX, CODE) \
  ({{(((N)-1)*8){1'b0}}, 8'(CODE)} << ((IDX)*8))

// File: rtl/fault_log_fifo.sv
// Secondary-fault log: DEPTH-entry show-ahead FIFO with saturating drop count.
// Ports: push_i/pop_i/clr_i/data_i in; vld_o, data_o (head), drop_o out.
module fault_log_fifo
  import fault_recorder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic         vld_o,
  output logic [W-1:0] data_o,
  output logic [7:0]   drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic [7:0]   drop_q, drop_d;
  logic [W-1:0] mem_q [DEPTH];

  logic empty, full, do_push, do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  assign do_pop  = pop_i & ~empty;
  // A pop frees the slot in the same cycle, so a full log still accepts
  assign do_push = push_i & (~full | do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    drop_d = drop_q;
    if (clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
      drop_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      if (push_i && !do_push && drop_q != 8'hFF)
        drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      drop_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      drop_q <= drop_d;
      if (do_push && !clr_i)
        mem_q[wptr_q[AW-1:0]] <= data_i;
    end
  end

  assign vld_o  = ~empty;
  assign data_o = empty ? '0 : mem_q[rptr_q[AW-1:0]];
  assign drop_o = drop_q;

endmodule

// File: rtl/fault_recorder.sv
// First-fault latch with halt, sticky pending vector and secondary-fault log.
// Ports: fault_in/fault_mask/addr_bus/clr/pop in; primary, pending, log out.
module fault_recorder
  import fault_recorder_pkg::*;
#(
  parameter int                  NSRC      = 18,
  parameter int                  XLEN      = 32,
  parameter int                  NADDR     = 4,
  parameter int                  ASELW     = 2,
  parameter int                  DEPTH     = 4,
  parameter logic [NSRC*8-1:0]     CAUSE_MAP = '0,
  parameter logic [NSRC*ASELW-1:0] ASEL_MAP  = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NSRC-1:0]         fault_in,
  input  logic [NSRC-1:0]         fault_mask,
  input  logic [NADDR*XLEN-1:0]   addr_bus,
  input  logic                    clr,
  input  logic                    pop,
  output logic                    halt,
  output logic                    fault,
  output logic [7:0]              fault_cause,
  output logic [$clog2(NSRC)-1:0] fault_src,
  output logic [XLEN-1:0]         fault_addr,
  output logic [NSRC-1:0]         pending,
  output logic                    log_vld,
  output logic [7:0]              log_cause,
  output logic [$clog2(NSRC)-1:0] log_src,
  output logic [XLEN-1:0]         log_addr,
  output logic [7:0]              log_drop
);

  localparam int SW = $clog2(NSRC);
  localparam int EW = 8 + SW + XLEN;

  logic [NSRC-1:0]  eff;
  logic             any;
  logic [SW-1:0]    w_src;
  logic [7:0]       w_cause;
  logic [ASELW-1:0] w_sel;
  logic [XLEN-1:0]  w_addr;

  fr_state_e        state_q, state_d;
  logic             fault_q, fault_d;
  logic [7:0]       cause_q, cause_d;
  logic [SW-1:0]    src_q, src_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic [NSRC-1:0]  pend_q, pend_d;
  logic             push;
  logic [EW-1:0]    head;

  assign eff = fault_in & ~fault_mask;
  assign any = |eff;

  // Descending scan so the lowest set index wins
  always_comb begin
    w_src   = '0;
    w_cause = '0;
    w_sel   = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eff[i]) begin
        w_src   = SW'(i);
        w_cause = CAUSE_MAP[i*8 +: 8];
        w_sel   = ASEL_MAP[i*ASELW +: ASELW];
      end
    end
  end

  // Out-of-range selects fall through to bus 0
  always_comb begin
    w_addr = addr_bus[0 +: XLEN];
    for (int k = 0; k < NADDR; k++) begin
      if (int'(w_sel) == k) w_addr = addr_bus[k*XLEN +: XLEN];
    end
  end

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    cause_d = cause_q;
    src_d   = src_q;
    addr_d  = addr_q;
    pend_d  = pend_q;
    push    = 1'b0;
    if (clr) begin
      state_d = FR_IDLE;
      fault_d = 1'b0;
      cause_d = '0;
      src_d   = '0;
      addr_d  = '0;
      pend_d  = '0;
    end else begin
      pend_d = pend_q | eff;
      unique case (state_q)
        FR_IDLE: begin
          if (any) begin
            state_d = FR_FAULTED;
            fault_d = 1'b1;
            cause_d = w_cause;
            src_d   = w_src;
            addr_d  = w_addr;
          end
        end
        FR_FAULTED: begin
          push = any;
        end
        default: state_d = FR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FR_IDLE;
      fault_q <= 1'b0;
      cause_q <= '0;
      src_q   <= '0;
      addr_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      cause_q <= cause_d;
      src_q   <= src_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
    end
  end

  fault_log_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_log (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr),
    .push_i (push),
    .pop_i  (pop),
    .data_i ({w_cause, w_src, w_addr}),
    .vld_o  (log_vld),
    .data_o (head),
    .drop_o (log_drop)
  );

  assign {log_cause, log_src, log_addr} = head;

  assign halt        = fault_q;
  assign fault       = fault_q;
  assign fault_cause = cause_q;
  assign fault_src   = src_q;
  assign fault_addr  = addr_q;
  assign pending     = pend_q;

endmodule
